// File: rtl/wb_arb2_if.sv
// Bundle of both Wishbone master ports and the shared slave port of wb_arb2.
// Latency: none, wiring only.
// Backpressure: carried by the Wishbone stb/ack handshake on these signals.
interface wb_arb2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    // master side, indexed/sliced per master (slice i belongs to master i)
    logic [1:0]      m_cyc_i;
    logic [1:0]      m_stb_i;
    logic [1:0]      m_we_i;
    logic [2*SW-1:0] m_sel_i;
    logic [2*AW-1:0] m_adr_i;
    logic [2*DW-1:0] m_dat_i;
    logic [DW-1:0]   m_dat_o;
    logic [1:0]      m_ack_o;
    logic [1:0]      m_err_o;

    // shared slave side
    logic            s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [SW-1:0]   s_sel_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;

    logic [1:0]      grant_o;

    // arbiter view: it is the slave of both masters and drives the RAM port
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output grant_o
    );

    // environment view: the two masters plus the RAM behind the arbiter
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  grant_o
    );
endinterface

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter in front of one single-port slave, with stall watchdog.
// Latency: 1 cycle from cyc in IDLE to the request appearing on the slave; ack/data return is combinational.
// Backpressure: owner keeps the bus for its whole cyc; the other master waits, a stalled slave yields err.
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_ni,
    wb_arb2_if.slave bus
);
    localparam int SW      = DW / 8;
    localparam int WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t         st;
    logic           last;   // master granted most recently out of IDLE
    logic [WDW-1:0] wd;     // strobed cycles waited without ack
    logic [1:0]     err;
    logic [1:0]     grant;
    logic           own1;   // current owner is master 1

    assign own1 = (st == G1);

    // Route the owner's request to the slave; an idle arbiter drives an all-zero request.
    // stb is gated with the owner's cyc so a released master can never strobe the slave.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        if (st != IDLE) begin
            bus.s_cyc_o = bus.m_cyc_i[own1];
            bus.s_stb_o = bus.m_cyc_i[own1] & bus.m_stb_i[own1];
            bus.s_we_o  = bus.m_we_i[own1];
            bus.s_sel_o = own1 ? bus.m_sel_i[2*SW-1:SW] : bus.m_sel_i[SW-1:0];
            bus.s_adr_o = own1 ? bus.m_adr_i[2*AW-1:AW] : bus.m_adr_i[AW-1:0];
            bus.s_dat_o = own1 ? bus.m_dat_i[2*DW-1:DW] : bus.m_dat_i[DW-1:0];
        end
    end

    // Return path: ack follows the state of this cycle, so a late ack still reaches its owner.
    assign bus.m_ack_o = {bus.s_ack_i & (st == G1), bus.s_ack_i & (st == G0)};
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_err_o = err;
    assign bus.grant_o = grant;

    // Arbitration FSM with registered grant/err, plus the stall watchdog.
    // Later assignments to wd in the state case win, clearing it on every ownership change.
    // last only moves on grants out of IDLE; a direct handover does not update it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            st    <= IDLE;
            last  <= 1'b1;
            wd    <= '0;
            err   <= 2'b00;
            grant <= 2'b00;
        end else begin
            err <= 2'b00;
            if (TIMEOUT == 0 || bus.s_ack_i || !bus.s_stb_o) begin
                wd <= '0;
            end else if (wd == WDW'(WD_LAST)) begin
                wd  <= '0;
                err <= own1 ? 2'b10 : 2'b01;
            end else begin
                wd <= wd + WDW'(1);
            end

            case (st)
                IDLE: begin
                    if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || last)) begin
                        st    <= G0;
                        grant <= 2'b01;
                        last  <= 1'b0;
                        wd    <= '0;
                    end else if (bus.m_cyc_i[1]) begin
                        st    <= G1;
                        grant <= 2'b10;
                        last  <= 1'b1;
                        wd    <= '0;
                    end
                end
                G0: begin
                    if (!bus.m_cyc_i[0]) begin
                        wd <= '0;
                        if (bus.m_cyc_i[1]) begin
                            st    <= G1;
                            grant <= 2'b10;
                        end else begin
                            st    <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                G1: begin
                    if (!bus.m_cyc_i[1]) begin
                        wd <= '0;
                        if (bus.m_cyc_i[0]) begin
                            st    <= G0;
                            grant <= 2'b01;
                        end else begin
                            st    <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    st    <= IDLE;
                    grant <= 2'b00;
                    wd    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// Testbench for wb_arb2: two scripted masters, a small RAM stub behind the arbiter, ack scoreboard.
// Latency: checks the 1-cycle grant latency and watchdog/ack timing cycle by cycle.
// Backpressure: RAM stub can add wait states or never ack to exercise the watchdog.
module tb_wb_arb2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arb2_if #(.AW(AW), .DW(DW)) bus ();

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] dat;
    } sb_t;

    sb_t sbq0[$];
    sb_t sbq1[$];
    int  checks    = 0;
    int  errors    = 0;
    int  ack_cnt0  = 0;
    int  ack_cnt1  = 0;

    // RAM stub: registered ack after 'lat' extra wait cycles, or never when no_ack is set
    logic [31:0] mem [0:63];
    logic        ack_q     = 1'b0;
    logic        no_ack    = 1'b0;
    logic        ack_force = 1'b0;
    logic [31:0] rd_q      = '0;
    int          lat       = 0;
    int          cnt       = 0;

    assign bus.s_ack_i = ack_q | ack_force;
    assign bus.s_dat_i = rd_q;

    always @(posedge clk) begin
        if (bus.s_cyc_o && bus.s_stb_o && !ack_q && !no_ack) begin
            if (cnt >= lat) begin
                ack_q <= 1'b1;
                cnt   <= 0;
                if (bus.s_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.s_sel_o[b]) mem[bus.s_adr_o[7:2]][b*8 +: 8] <= bus.s_dat_o[b*8 +: 8];
                end else begin
                    rd_q <= mem[bus.s_adr_o[7:2]];
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            ack_q <= 1'b0;
            cnt   <= 0;
        end
    end

    // Scoreboard: every master ack must match a queued expectation; reads check data
    always @(negedge clk) begin
        sb_t e;
        if (bus.m_ack_o[0] === 1'b1) begin
            ack_cnt0++;
            checks++;
            if (sbq0.size() == 0) begin
                errors++;
                $display("FAIL m0_ack_unexpected: ack=1 required=0");
            end else begin
                e = sbq0.pop_front();
                if (!e.we && bus.m_dat_o !== e.dat) begin
                    errors++;
                    $display("FAIL m0_rdata: got=%h required=%h", bus.m_dat_o, e.dat);
                end
            end
        end
        if (bus.m_ack_o[1] === 1'b1) begin
            ack_cnt1++;
            checks++;
            if (sbq1.size() == 0) begin
                errors++;
                $display("FAIL m1_ack_unexpected: ack=1 required=0");
            end else begin
                e = sbq1.pop_front();
                if (!e.we && bus.m_dat_o !== e.dat) begin
                    errors++;
                    $display("FAIL m1_rdata: got=%h required=%h", bus.m_dat_o, e.dat);
                end
            end
        end
        checks++;
        if (!(bus.grant_o inside {2'b00, 2'b01, 2'b10}) || (bus.m_ack_o & bus.m_err_o) !== 2'b00) begin
            errors++;
            $display("FAIL invariant: grant=%b ack=%b err=%b required grant idle/one-hot and no ack+err",
                     bus.grant_o, bus.m_ack_o, bus.m_err_o);
        end
    end

    task automatic raise(input int i, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input bit exp_ack);
        sb_t e;
        e.we  = we;
        e.dat = dat;
        if (exp_ack) begin
            if (i == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
        end
        bus.m_cyc_i[i]          = 1'b1;
        bus.m_stb_i[i]          = 1'b1;
        bus.m_we_i[i]           = we;
        bus.m_sel_i[i*4 +: 4]   = 4'hF;
        bus.m_adr_i[i*32 +: 32] = adr;
        bus.m_dat_i[i*32 +: 32] = we ? dat : 32'h0;
    endtask

    task automatic drop(input int i);
        bus.m_cyc_i[i] = 1'b0;
        bus.m_stb_i[i] = 1'b0;
    endtask

    task automatic wait_ack(input int i, output bit got);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.m_ack_o[i] === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b00 || bus.m_err_o !== 2'b00 || bus.m_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b err=%b ack=%b required 00/00/00",
                     bus.grant_o, bus.m_err_o, bus.m_ack_o);
        end
        checks++;
        if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_slave: cyc=%b stb=%b adr=%h required 0/0/0",
                     bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        bit got;
        @(posedge clk); #1;
        raise(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b00) begin
            errors++;
            $display("FAIL single_latency: grant=%b required=00", bus.grant_o);
        end
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: grant=%b required=01", bus.grant_o);
        end
        checks++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b111 || bus.s_adr_o !== 32'h10 ||
            bus.s_dat_o !== 32'hDEADBEEF || bus.s_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL single_slave_req: cyc/stb/we=%b%b%b adr=%h dat=%h sel=%h required 111/10/deadbeef/f",
                     bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
        end
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL single_write_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        checks++;
        if (bus.s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_release_cyc: s_cyc=%b required=0", bus.s_cyc_o);
        end
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: grant=%b required=00", bus.grant_o);
        end
        @(posedge clk); #1;
        raise(0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL single_read_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(0);
    endtask

    task automatic test_tie;
        bit got;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        raise(0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        raise(1, 1'b1, 32'h24, 32'h11112222, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b01) begin
            errors++;
            $display("FAIL tie_first: grant=%b required=01", bus.grant_o);
        end
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL tie_m0_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b10) begin
            errors++;
            $display("FAIL tie_handover: grant=%b required=10", bus.grant_o);
        end
        wait_ack(1, got);
        checks++;
        if (!got) begin errors++; $display("FAIL tie_m1_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(1);
        repeat (2) @(posedge clk); #1;
        raise(0, 1'b0, 32'h24, 32'h11112222, 1'b1);
        raise(1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b10) begin
            errors++;
            $display("FAIL tie_round_robin: grant=%b required=10", bus.grant_o);
        end
        wait_ack(1, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rr_m1_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(1);
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rr_m0_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(0);
    endtask

    task automatic test_no_preempt;
        bit got;
        int a0;
        int a1;
        repeat (2) @(posedge clk); #1;
        a0 = ack_cnt0;
        a1 = ack_cnt1;
        raise(1, 1'b1, 32'h20, 32'hA0A0A0A0, 1'b1);
        @(posedge clk); #1;
        raise(0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                raise(1, 1'b1, 32'h20 + 32'(4*k), 32'hA0A0A0A0 + 32'(k), 1'b1);
            end
            wait_ack(1, got);
            checks++;
            if (!got) begin errors++; $display("FAIL nopre_m1_ack%0d: ack=0 required=1", k); end
        end
        @(posedge clk); #1;
        checks++;
        if (ack_cnt0 !== a0 || ack_cnt1 - a1 !== 3) begin
            errors++;
            $display("FAIL nopre_counts: m0_acks=%0d m1_acks=%0d required 0 and 3",
                     ack_cnt0 - a0, ack_cnt1 - a1);
        end
        checks++;
        if (bus.grant_o !== 2'b10) begin
            errors++;
            $display("FAIL nopre_hold: grant=%b required=10", bus.grant_o);
        end
        drop(1);
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL nopre_m0_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(0);
    endtask

    task automatic test_watchdog;
        logic exp;
        repeat (2) @(posedge clk); #1;
        no_ack = 1'b1;
        raise(0, 1'b1, 32'h30, 32'h12345678, 1'b0);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            exp = (n >= 5) && ((n - 5) % 4 == 0);
            checks++;
            if (bus.m_err_o !== {1'b0, exp} || bus.m_ack_o !== 2'b00) begin
                errors++;
                $display("FAIL wd_cycle%0d: err=%b ack=%b required err=%b ack=00",
                         n, bus.m_err_o, bus.m_ack_o, {1'b0, exp});
            end
        end
        @(posedge clk); #1;
        drop(0);
        no_ack = 1'b0;
    endtask

    task automatic test_ack_threshold;
        int ack_n;
        repeat (2) @(posedge clk); #1;
        lat   = 2;
        ack_n = -1;
        raise(0, 1'b1, 32'h34, 32'hCAFEF00D, 1'b1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++;
            if (bus.m_err_o !== 2'b00) begin
                errors++;
                $display("FAIL thr_err_cycle%0d: err=%b required=00", n, bus.m_err_o);
            end
            if (bus.m_ack_o[0] === 1'b1 && ack_n < 0) begin
                ack_n = n;
                @(posedge clk); #1;
                drop(0);
            end
        end
        checks++;
        if (ack_n !== 4) begin
            errors++;
            $display("FAIL thr_ack_cycle: got=%0d required=4", ack_n);
        end
        lat = 0;
    endtask

    task automatic test_reset_mid;
        bit got;
        repeat (2) @(posedge clk); #1;
        raise(0, 1'b1, 32'h40, 32'h0BADF00D, 1'b1);
        @(posedge clk); #1;
        raise(1, 1'b1, 32'h48, 32'h77777777, 1'b0);
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rst_m0_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        no_ack = 1'b1;
        drop(0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b10 || bus.s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_grant: grant=%b stb=%b required 10/1", bus.grant_o, bus.s_stb_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drop(1);
        ack_force = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b00 || bus.s_cyc_o !== 1'b0 || bus.m_err_o !== 2'b00 ||
            bus.m_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid: grant=%b s_cyc=%b err=%b ack=%b required 00/0/00/00",
                     bus.grant_o, bus.s_cyc_o, bus.m_err_o, bus.m_ack_o);
        end
        @(posedge clk); #1;
        ack_force = 1'b0;
        no_ack    = 1'b0;
        raise(0, 1'b1, 32'h44, 32'h5555AAAA, 1'b1);
        raise(1, 1'b0, 32'h44, 32'h5555AAAA, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_o !== 2'b01) begin
            errors++;
            $display("FAIL rst_tie_m0: grant=%b required=01", bus.grant_o);
        end
        wait_ack(0, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rst_tie_m0_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(0);
        wait_ack(1, got);
        checks++;
        if (!got) begin errors++; $display("FAIL rst_tie_m1_ack: ack=0 required=1"); end
        @(posedge clk); #1;
        drop(1);
    endtask

    initial begin
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_sel_i = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        rst_n       = 1'b0;
        test_reset;
        test_single;
        test_tie;
        test_no_preempt;
        test_watchdog;
        test_ack_threshold;
        test_reset_mid;
        repeat (3) @(posedge clk);
        checks++;
        if (sbq0.size() != 0 || sbq1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending m0=%0d m1=%0d required 0/0", sbq0.size(), sbq1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
